loop_replay_ctrl: RTL and testbench
===================================

Name: loop_replay_ctrl

Overview:
- Sequencer for the loop-buffer uop cache (1-cycle-latency BRAM).
- Fills the BRAM with the instructions of a detected loop body, then replays them in order to decode over a valid/ready handshake, wrapping at the loop end, until a mispredict signals loop exit.
- On exit, flushes the front end and redirects fetch to the captured exit PC.

Parameters:
- ADDR_W, 6, BRAM address width; depth = 2**ADDR_W entries (word-addressed, stride 1).
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- fill_valid  in  1  instruction of the loop body presented for buffering
- fill_instr  in  DATA_W  instruction to buffer
- fill_last  in  1  qualifies fill_valid: this is the closing backward branch
- fill_pc  in  32  PC of fill_instr
- start  in  1  begin replay (honoured only in READY)
- mispredict  in  1  loop exit / wrong path detected
- out_valid  out  1  replayed instruction available
- out_ready  in  1  decode accepts out_instr
- out_instr  out  DATA_W  replayed instruction
- bram_we  out  1  BRAM write enable
- bram_waddr  out  ADDR_W  write address
- bram_wdata  out  DATA_W  write data
- bram_re  out  1  BRAM read enable
- bram_raddr  out  ADDR_W  read address
- bram_rdata  in  DATA_W  read data, valid the cycle after bram_re
- busy  out  1  state != IDLE
- flush  out  1  one-cycle pulse
- redirect_pc  out  32  fetch target, valid with flush
- overflow  out  1  one-cycle pulse: loop body exceeded depth
- iter_count  out  16  completed replay passes, saturating

Behaviour:
- Reset: state=IDLE. All outputs 0: out_valid, out_instr, bram_we/re, addresses, busy, flush, redirect_pc, overflow, iter_count. Length and exit PC registers cleared. Skid buffer emptied.
- States: IDLE, FILL, READY, REPLAY, EXIT.
- IDLE:
  - fill_valid: write entry 0 (bram_we combinational with fill_valid, waddr=0).
  - fill_valid with !fill_last: go to FILL.
  - fill_valid with fill_last: len=1, exit_pc=fill_pc+4, go to READY.
- FILL:
  - Each fill_valid writes at waddr = count, then count+1.
  - fill_last: len = count+1, exit_pc = fill_pc+4, go to READY.
  - Writing entry 2**ADDR_W-1 without fill_last: overflow pulse, go to IDLE with no BRAM contents retained logically.
- READY: holds contents. start: rptr=0, go to REPLAY.
- REPLAY:
  - Two-entry output FIFO (skid) plus at most one read in flight.
  - Issue bram_re with raddr=rptr when occupancy + inflight < 2.
  - rptr advances modulo len. On wrap to 0, iter_count+1, saturating at 0xFFFF.
  - Returning data is pushed into the FIFO the next cycle.
  - out_valid = FIFO non-empty; out_instr = head. Pop on out_valid && out_ready.
  - out_instr stays stable while out_valid && !out_ready.
  - Steady-state throughput: 1 instruction/cycle with out_ready held high.
  - First out_valid: 2 cycles after start is sampled.
- mispredict in REPLAY or FILL (highest priority, overrides start/fill/reads in the same cycle):
  - Drop the in-flight read and clear the FIFO; out_valid=0 the next cycle.
  - Go to EXIT.
  - In FILL, exit_pc = fill_pc of the current cycle +4 if fill_valid, else the last captured fill_pc+4.
- mispredict in IDLE or READY: ignored.
- EXIT: flush=1 and redirect_pc=exit_pc for exactly one cycle. Then IDLE; iter_count retained until the next start, which clears it.
- fill_valid outside IDLE/FILL: ignored. start outside READY: ignored.
- Address arithmetic: ADDR_W bits. len is ADDR_W+1 bits, range 1..2**ADDR_W-1.
- Reset asserted mid-operation: immediate return to reset values; no flush pulse.

Test Plan:
- Fill 4 instrs (0xA0..0xA3, last at pc 0x100), start, out_ready=1 -> bram_we at waddr 0..3; out_instr sequence A0,A1,A2,A3,A0,A1,… one per cycle after 2-cycle latency; iter_count=1 after the 4th pop.
- Same loop, out_ready toggled 1/0 each cycle -> no duplicate or lost instr; out_instr stable while stalled; bram_re never causes occupancy+inflight>2.
- mispredict during REPLAY with a read in flight -> next cycle out_valid=0, flush=1, redirect_pc=0x104; following cycle busy=0.
- 63 fill_valid with no fill_last (ADDR_W=6) -> overflow pulse on the 63rd write, state IDLE, start ignored.
- Single-instruction loop (fill_last on the first fill) -> continuous replay of the same instr; iter_count increments every pop, saturates at 0xFFFF.
- Reset asserted mid-REPLAY -> outputs 0 asynchronously, no flush; a new fill is accepted from IDLE afterwards.

Source files
------------

// File: rtl/loop_replay_ctrl.sv
// loop_replay_ctrl
//   Sequencer for the loop-buffer uop cache. Captures a detected loop body
//   into a 1-cycle-latency BRAM, replays it to decode over valid/ready
//   (wrapping at the loop end) until a mispredict ends the loop. It then
//   flushes the front end and redirects fetch to the loop exit PC.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   fill_valid/instr/last/pc      loop body capture stream
//   start                         begin replay of a captured loop
//   mispredict                    loop exit / wrong path detected
//   out_valid/ready/instr         replay stream towards decode
//   bram_we/waddr/wdata           BRAM write port
//   bram_re/raddr/rdata           BRAM read port (rdata valid the cycle after re)
//   busy                          controller not idle
//   flush, redirect_pc            one-cycle front-end flush with fetch target
//   overflow                      one-cycle pulse: loop body too long to hold
//   iter_count                    completed replay passes, saturating
module loop_replay_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_instr,
    input  logic              fill_last,
    input  logic [31:0]       fill_pc,
    input  logic              start,
    input  logic              mispredict,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic              bram_re,
    output logic [ADDR_W-1:0] bram_raddr,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              busy,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic              overflow,
    output logic [15:0]       iter_count
);

    localparam int LEN_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_REPLAY = 3'd3;
    localparam logic [2:0] S_EXIT   = 3'd4;

    // The longest loop that fits is 2**ADDR_W-1 entries, so writing this
    // index without the closing branch means the body cannot be held.
    localparam logic [ADDR_W-1:0] LAST_FILL_IDX = ADDR_W'((2 ** ADDR_W) - 2);

    logic [2:0]        state;
    logic [ADDR_W-1:0] wcnt;
    logic [LEN_W-1:0]  len;
    logic [31:0]       exit_pc;
    logic [31:0]       last_pc;
    logic [ADDR_W-1:0] rptr;
    logic              rd_vld_p1;
    logic [1:0]        occ;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic [15:0]       iter_q;

    logic              fill_acc;
    logic              pop;
    logic              push;
    logic [2:0]        slots;
    logic [1:0]        occ_left;
    logic [LEN_W-1:0]  rptr_inc;
    logic              wrap;

    always_comb begin
        fill_acc = fill_valid && ((state == S_IDLE) ||
                                  ((state == S_FILL) && !mispredict));
        pop      = (occ != 2'd0) && out_ready;
        push     = rd_vld_p1;
        occ_left = occ - {1'b0, pop};
        // A pop in this cycle frees its slot immediately, which is what lets
        // the read pipeline sustain one instruction per cycle.
        slots    = {1'b0, occ} + {2'b0, rd_vld_p1} - {2'b0, pop};
        rptr_inc = {1'b0, rptr} + LEN_W'(1);
        wrap     = (rptr_inc == len);
    end

    assign bram_we     = fill_acc;
    assign bram_waddr  = (state == S_FILL) ? wcnt : '0;
    assign bram_wdata  = fill_acc ? fill_instr : '0;
    assign bram_re     = (state == S_REPLAY) && !mispredict && (slots < 3'd2);
    assign bram_raddr  = rptr;
    assign out_valid   = (occ != 2'd0);
    assign out_instr   = head;
    assign busy        = (state != S_IDLE);
    assign flush       = (state == S_EXIT);
    assign redirect_pc = flush ? exit_pc : 32'd0;
    assign overflow    = (state == S_FILL) && fill_valid && !fill_last &&
                         !mispredict && (wcnt == LAST_FILL_IDX);
    assign iter_count  = iter_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            len       <= '0;
            exit_pc   <= '0;
            last_pc   <= '0;
            rptr      <= '0;
            rd_vld_p1 <= 1'b0;
            occ       <= 2'd0;
            head      <= '0;
            tail      <= '0;
            iter_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fill_valid) begin
                        last_pc <= fill_pc;
                        if (fill_last) begin
                            len     <= LEN_W'(1);
                            exit_pc <= fill_pc + 32'd4;
                            state   <= S_READY;
                        end else begin
                            wcnt  <= ADDR_W'(1);
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (mispredict) begin
                        exit_pc <= (fill_valid ? fill_pc : last_pc) + 32'd4;
                        state   <= S_EXIT;
                    end else if (fill_valid) begin
                        last_pc <= fill_pc;
                        if (fill_last) begin
                            len     <= {1'b0, wcnt} + LEN_W'(1);
                            exit_pc <= fill_pc + 32'd4;
                            state   <= S_READY;
                        end else if (wcnt == LAST_FILL_IDX) begin
                            state <= S_IDLE;
                        end else begin
                            wcnt <= wcnt + ADDR_W'(1);
                        end
                    end
                end
                S_READY: begin
                    if (start) begin
                        rptr      <= '0;
                        iter_q    <= '0;
                        rd_vld_p1 <= 1'b0;
                        occ       <= 2'd0;
                        state     <= S_REPLAY;
                    end
                end
                S_REPLAY: begin
                    if (mispredict) begin
                        rd_vld_p1 <= 1'b0;
                        occ       <= 2'd0;
                        state     <= S_EXIT;
                    end else begin
                        // read issue stage -> BRAM data returns next cycle
                        rd_vld_p1 <= bram_re;
                        if (bram_re) begin
                            rptr <= wrap ? '0 : rptr_inc[ADDR_W-1:0];
                            if (wrap && (iter_q != 16'hFFFF)) begin
                                iter_q <= iter_q + 16'd1;
                            end
                        end
                        // return stage -> two-entry skid FIFO, head drives decode
                        if (pop) begin
                            head <= tail;
                        end
                        if (push) begin
                            if (occ_left == 2'd0) begin
                                head <= bram_rdata;
                            end else begin
                                tail <= bram_rdata;
                            end
                        end
                        occ <= occ + {1'b0, push} - {1'b0, pop};
                    end
                end
                S_EXIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_replay_ctrl.sv
// Testbench for loop_replay_ctrl: table-driven fill/control vectors, hand
// sequences for exit, overflow and reset corner cases, and randomized replay
// checked against a stream-level model of the loop body.
module tb_loop_replay_ctrl;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              reset;
    logic              fill_valid;
    logic [DATA_W-1:0] fill_instr;
    logic              fill_last;
    logic [31:0]       fill_pc;
    logic              start;
    logic              mispredict;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_waddr;
    logic [DATA_W-1:0] bram_wdata;
    logic              bram_re;
    logic [ADDR_W-1:0] bram_raddr;
    logic [DATA_W-1:0] bram_rdata;
    logic              busy;
    logic              flush;
    logic [31:0]       redirect_pc;
    logic              overflow;
    logic [15:0]       iter_count;

    loop_replay_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .fill_valid(fill_valid), .fill_instr(fill_instr), .fill_last(fill_last),
        .fill_pc(fill_pc), .start(start), .mispredict(mispredict),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
        .bram_re(bram_re), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
        .busy(busy), .flush(flush), .redirect_pc(redirect_pc),
        .overflow(overflow), .iter_count(iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-cycle-latency BRAM
    logic [DATA_W-1:0] mem [DEPTH];
    initial bram_rdata = '0;
    always @(posedge clk) begin
        if (bram_we) mem[bram_waddr] <= bram_wdata;
        if (bram_re) bram_rdata <= mem[bram_raddr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model: the loop body as a list, the exit PC, and counts of
    // reads issued and instructions delivered since the last start.
    logic [DATA_W-1:0] loop_q[$];
    logic [31:0]       exp_exit;
    int                issued;
    int                pops;

    typedef struct {
        logic        fv;
        logic [31:0] fi;
        logic        fl;
        logic [31:0] fpc;
        logic        st;
        logic        mp;
        logic        exp_we;
        logic [5:0]  exp_waddr;
        logic        exp_busy;
        logic        exp_flush;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_iter();
        int v;
        v = issued / loop_q.size();
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic clear_inputs();
        fill_valid = 0; fill_instr = '0; fill_last = 0; fill_pc = '0;
        start = 0; mispredict = 0; out_ready = 0;
    endtask

    // Capture an n-instruction loop from IDLE; body is base, base+1, ...
    task automatic fill_loop(input int n, input logic [31:0] pc0, input logic [31:0] base);
        loop_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fill_valid = 1; fill_instr = base + i; fill_last = (i == n - 1);
            fill_pc = pc0 + 4 * i;
            loop_q.push_back(base + i);
            #1;
            chk("fill_we", bram_we, 1);
            chk("fill_waddr", bram_waddr, i);
            @(posedge clk);
        end
        @(negedge clk);
        fill_valid = 0; fill_last = 0;
        #1;
        chk("fill_ready_busy", busy, 1);
        exp_exit = pc0 + 4 * n;
    endtask

    // mode 0: ready held high, 1: ready toggling, 2: random ready
    task automatic run_replay(input int ncyc, input int mode);
        logic              prev_stall;
        logic [DATA_W-1:0] prev_instr;
        logic              rdy;
        issued = 0; pops = 0; prev_stall = 0; prev_instr = '0;
        @(negedge clk);
        start = 1; out_ready = 0;
        #1;
        chk("start_no_re", bram_re, 0);
        @(posedge clk);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start = 0;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : ($urandom_range(0, 3) != 0);
            out_ready = rdy;
            #1;
            if (c < 2) chk("latency_valid", out_valid, 0);
            else if (c == 2 || mode == 0) chk("valid_stream", out_valid, 1);
            chk("iter_count", iter_count, exp_iter());
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_instr", out_instr, prev_instr);
            end
            if (bram_re) begin
                chk("raddr", bram_raddr, issued % loop_q.size());
                issued++;
            end
            if (out_valid) begin
                chk("out_instr", out_instr, loop_q[pops % loop_q.size()]);
                if (rdy) pops++;
            end
            chk("outstanding_le2", (issued - pops) <= 2, 1);
            prev_stall = out_valid && !rdy;
            prev_instr = out_instr;
            @(posedge clk);
        end
        chk("progress", pops > 0, 1);
    endtask

    task automatic check_exit(input logic [31:0] pc);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("exit_out_valid", out_valid, 0);
        chk("exit_flush", flush, 1);
        chk("exit_redirect", redirect_pc, pc);
        chk("exit_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("post_exit_flush", flush, 0);
        chk("post_exit_busy", busy, 0);
    endtask

    task automatic do_mispredict();
        int keep;
        @(negedge clk);
        mispredict = 1;
        #1;
        chk("mp_no_re", bram_re, 0);
        keep = exp_iter();
        @(posedge clk);
        check_exit(exp_exit);
        chk("iter_retained", iter_count, keep);
    endtask

    task automatic fill_mispredict(input bit with_fill);
        @(negedge clk);
        fill_valid = 1; fill_instr = 32'h11; fill_pc = 32'h200;
        @(posedge clk);
        @(negedge clk);
        fill_instr = 32'h12; fill_pc = 32'h204;
        @(posedge clk);
        @(negedge clk);
        fill_valid = with_fill; fill_instr = 32'h13; fill_pc = 32'h300; mispredict = 1;
        #1;
        chk("fill_mp_we", bram_we, 0);
        @(posedge clk);
        check_exit(with_fill ? 32'h304 : 32'h208);
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_re", bram_re, 0);
        chk("rst_raddr", bram_raddr, 0);
        reset = 0;

        // fv fi fl fpc st mp | we waddr busy_after flush_after
        vq.push_back('{0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 32'h0,  0, 32'h0,   0, 1, 0, 0, 0, 0});
        vq.push_back('{0, 32'h0,  0, 32'h0,   1, 0, 0, 0, 0, 0});
        vq.push_back('{1, 32'hA0, 0, 32'hF4,  0, 0, 1, 0, 1, 0});
        vq.push_back('{1, 32'hA1, 0, 32'hF8,  0, 0, 1, 1, 1, 0});
        vq.push_back('{0, 32'h0,  0, 32'h0,   0, 0, 0, 2, 1, 0});
        vq.push_back('{1, 32'hA2, 0, 32'hFC,  0, 0, 1, 2, 1, 0});
        vq.push_back('{1, 32'hA3, 1, 32'h100, 0, 0, 1, 3, 1, 0});
        vq.push_back('{1, 32'hA9, 0, 32'h200, 0, 0, 0, 0, 1, 0});
        vq.push_back('{0, 32'h0,  0, 32'h0,   0, 1, 0, 0, 1, 0});
        foreach (vq[i]) begin
            @(negedge clk);
            fill_valid = vq[i].fv; fill_instr = vq[i].fi; fill_last = vq[i].fl;
            fill_pc = vq[i].fpc; start = vq[i].st; mispredict = vq[i].mp;
            #1;
            chk("vec_we", bram_we, vq[i].exp_we);
            if (vq[i].exp_we) begin
                chk("vec_waddr", bram_waddr, vq[i].exp_waddr);
                chk("vec_wdata", bram_wdata, vq[i].fi);
            end
            @(posedge clk);
            #1;
            chk("vec_busy", busy, vq[i].exp_busy);
            chk("vec_flush", flush, vq[i].exp_flush);
        end
        @(negedge clk);
        clear_inputs();
        loop_q.delete();
        for (int i = 0; i < 4; i++) loop_q.push_back(32'hA0 + i);
        exp_exit = 32'h104;

        // A0..A3 at full rate, then exit with a read in flight
        run_replay(16, 0);
        do_mispredict();

        // Same loop with decode stalling every other cycle
        fill_loop(4, 32'hF4, 32'hA0);
        run_replay(40, 1);
        do_mispredict();

        // Random loop lengths and random backpressure
        for (int t = 0; t < 4; t++) begin
            fill_loop($urandom_range(1, 12), 32'h1000 * (t + 1), $urandom);
            run_replay($urandom_range(20, 60), 2);
            do_mispredict();
        end

        fill_mispredict(1);
        fill_mispredict(0);

        // Loop body one entry longer than the buffer can hold
        for (int i = 0; i < DEPTH - 1; i++) begin
            @(negedge clk);
            fill_valid = 1; fill_last = 0; fill_instr = 32'h700 + i; fill_pc = 32'h700 + 4 * i;
            #1;
            chk("ovf_we", bram_we, 1);
            chk("ovf_waddr", bram_waddr, i);
            chk("ovf_pulse", overflow, i == DEPTH - 2);
            @(posedge clk);
        end
        @(negedge clk);
        fill_valid = 0; start = 1;
        #1;
        chk("ovf_idle", busy, 0);
        chk("ovf_pulse_end", overflow, 0);
        @(posedge clk);
        @(negedge clk);
        start = 0;
        #1;
        chk("ovf_start_ignored", busy, 0);
        chk("ovf_no_valid", out_valid, 0);

        // Asynchronous reset in the middle of replay
        fill_loop(5, 32'h400, $urandom);
        run_replay(10, 2);
        @(negedge clk);
        #2;
        reset = 1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_instr", out_instr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_re", bram_re, 0);
        chk("arst_iter", iter_count, 0);
        chk("arst_flush", flush, 0);
        @(posedge clk);
        #1;
        chk("arst_no_flush", flush, 0);
        @(negedge clk);
        reset = 0;
        clear_inputs();
        fill_loop(3, 32'h500, $urandom);
        run_replay(20, 2);
        do_mispredict();

        // Single-instruction loop until iter_count saturates
        fill_loop(1, 32'h600, 32'h55);
        run_replay(65545, 0);
        chk("iter_saturated", iter_count, 16'hFFFF);
        do_mispredict();
        fill_loop(2, 32'h800, $urandom);
        run_replay(8, 0);
        do_mispredict();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
